// File: rtl/mem_init_pkg.sv
// Shared types and constants for the dual-port memory initiator.
package mem_init_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned MASK_W          = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 64;
  // TIMEOUT tops out at 255, so an 8-bit cycle counter is enough.
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone,
    StErr
  } port_state_e;

endpackage

// File: rtl/mem_port_fsm.sv
// One initiator port: accepts a request, drives the memory strobe until a
// response or timeout arrives, then pulses done or err for one cycle.
module mem_port_fsm
  import mem_init_pkg::*;
#(
  parameter bit          WRITE_EN = 1'b0,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

  port_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  // Next-state: accept in idle, wait for resp or timeout while issuing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = addr;
          we_d    = WRITE_EN ? we : 1'b0;
          wdata_d = WRITE_EN ? wdata : '0;
          wmask_d = WRITE_EN ? wmask : '0;
          cnt_d   = '0;
          state_d = (addr[1:0] != 2'b00) ? StErr : StIssue;
        end
      end
      StIssue: begin
        if (mem_resp) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = StDone;
        end else if (cnt_q == LastCnt) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode purely from registered state, so strobes are glitch-free.
  always_comb begin
    ready     = (state_q == StIdle);
    done      = (state_q == StDone);
    err       = (state_q == StErr);
    mem_read  = (state_q == StIssue) && !we_q;
    mem_write = (state_q == StIssue) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
    rdata     = rdata_q;
  end

endmodule

// File: rtl/mem_initiator_dp.sv
// Dual-port memory initiator: read-only port A and read/write port B run
// independent FSMs with no ordering between them.
module mem_initiator_dp
  import mem_init_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [WORD_W-1:0] a_addr,
  output logic              a_ready,
  output logic [WORD_W-1:0] a_rdata,
  output logic              a_done,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [WORD_W-1:0] b_addr,
  input  logic [WORD_W-1:0] b_wdata,
  input  logic [MASK_W-1:0] b_wmask,
  output logic              b_ready,
  output logic [WORD_W-1:0] b_rdata,
  output logic              b_done,
  output logic              b_err,
  output logic              read_a,
  output logic [WORD_W-1:0] address_a,
  input  logic [WORD_W-1:0] rdata_a,
  input  logic              resp_a,
  output logic              read_b,
  output logic              write,
  output logic [WORD_W-1:0] address_b,
  output logic [WORD_W-1:0] wdata,
  output logic [MASK_W-1:0] wmask,
  input  logic [WORD_W-1:0] rdata_b,
  input  logic              resp_b
);

  // Port A never writes; its write-side outputs are constant and dropped.
  logic              unused_a_write;
  logic [WORD_W-1:0] unused_a_wdata;
  logic [MASK_W-1:0] unused_a_wmask;

  mem_port_fsm #(
    .WRITE_EN (1'b0),
    .TIMEOUT  (TIMEOUT)
  ) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .req       (a_req),
    .we        (1'b0),
    .addr      (a_addr),
    .wdata     ('0),
    .wmask     ('0),
    .ready     (a_ready),
    .rdata     (a_rdata),
    .done      (a_done),
    .err       (a_err),
    .mem_read  (read_a),
    .mem_write (unused_a_write),
    .mem_addr  (address_a),
    .mem_wdata (unused_a_wdata),
    .mem_wmask (unused_a_wmask),
    .mem_rdata (rdata_a),
    .mem_resp  (resp_a)
  );

  mem_port_fsm #(
    .WRITE_EN (1'b1),
    .TIMEOUT  (TIMEOUT)
  ) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .req       (b_req),
    .we        (b_we),
    .addr      (b_addr),
    .wdata     (b_wdata),
    .wmask     (b_wmask),
    .ready     (b_ready),
    .rdata     (b_rdata),
    .done      (b_done),
    .err       (b_err),
    .mem_read  (read_b),
    .mem_write (write),
    .mem_addr  (address_b),
    .mem_wdata (wdata),
    .mem_wmask (wmask),
    .mem_rdata (rdata_b),
    .mem_resp  (resp_b)
  );

endmodule

// File: tb/tb_mem_initiator_dp.sv
// Directed bench for mem_initiator_dp with a small behavioural memory that
// answers each strobe in its second cycle.
module tb_mem_initiator_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req;
  logic [31:0] a_addr;
  logic        a_ready;
  logic [31:0] a_rdata;
  logic        a_done;
  logic        a_err;
  logic        b_req;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_wmask;
  logic        b_ready;
  logic [31:0] b_rdata;
  logic        b_done;
  logic        b_err;
  logic        read_a;
  logic [31:0] address_a;
  logic [31:0] rdata_a;
  logic        resp_a;
  logic        read_b;
  logic        write;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata_b;
  logic        resp_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  int          a_cnt, b_cnt, na_strb, nb_strb;
  logic        en_a, en_b, rb_seen;

  always #5 clk = ~clk;

  mem_initiator_dp #(
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_addr    (a_addr),
    .a_ready   (a_ready),
    .a_rdata   (a_rdata),
    .a_done    (a_done),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_wmask   (b_wmask),
    .b_ready   (b_ready),
    .b_rdata   (b_rdata),
    .b_done    (b_done),
    .b_err     (b_err),
    .read_a    (read_a),
    .address_a (address_a),
    .rdata_a   (rdata_a),
    .resp_a    (resp_a),
    .read_b    (read_b),
    .write     (write),
    .address_b (address_b),
    .wdata     (wdata),
    .wmask     (wmask),
    .rdata_b   (rdata_b),
    .resp_b    (resp_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then update the memory model from the new strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (read_a) begin
      a_cnt++;
      na_strb++;
    end else begin
      a_cnt = 0;
    end
    resp_a  = en_a && read_a && (a_cnt == 2);
    rdata_a = read_a ? mem[address_a[9:2]] : 32'h0;
    if (read_b || write) begin
      b_cnt++;
      nb_strb++;
    end else begin
      b_cnt = 0;
    end
    if (read_b) rb_seen = 1'b1;
    resp_b = en_b && (read_b || write) && (b_cnt == 2);
    if (resp_b && write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[address_b[9:2]][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    rdata_b = read_b ? mem[address_b[9:2]] : 32'h0;
  endtask

  initial begin
    int n;
    int dca;
    int dcb;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0BAD_F00D;
    mem[24] = 32'hDEAD_BEEF;
    rst = 1'b1;
    a_req = 1'b0; a_addr = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_wmask = 4'h0;
    rdata_a = 32'h0; resp_a = 1'b0; rdata_b = 32'h0; resp_b = 1'b0;
    a_cnt = 0; b_cnt = 0; na_strb = 0; nb_strb = 0;
    en_a = 1'b1; en_b = 1'b1; rb_seen = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_strobes", {read_a, read_b, write}, 0);
    chk("rst_pulses", {a_done, a_err, b_done, b_err}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_address_b", address_b, 0);
    chk("rst_wmask", wmask, 0);
    rst = 1'b0;
    cyc();

    // Port A read of 0x60
    na_strb = 0;
    a_req = 1'b1; a_addr = 32'h60;
    cyc();
    a_req = 1'b0;
    chk("a_rd_strobe", read_a, 1);
    chk("a_rd_addr", address_a, 32'h60);
    chk("a_rd_not_ready", a_ready, 0);
    cyc();
    chk("a_rd_strobe_hold", read_a, 1);
    cyc();
    chk("a_rd_strobe_low", read_a, 0);
    chk("a_rd_done", a_done, 1);
    chk("a_rd_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("a_rd_strobe_cycles", na_strb, 2);
    cyc();
    chk("a_rd_done_once", a_done, 0);
    chk("a_rd_ready_again", a_ready, 1);

    // Port B masked write then read back
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h100; b_wdata = 32'h1122_3344; b_wmask = 4'b0101;
    cyc();
    b_req = 1'b0;
    chk("b_wr_write", write, 1);
    chk("b_wr_read_b", read_b, 0);
    chk("b_wr_wdata", wdata, 32'h1122_3344);
    chk("b_wr_wmask", wmask, 4'b0101);
    chk("b_wr_addr", address_b, 32'h100);
    cyc();
    cyc();
    chk("b_wr_done", b_done, 1);
    chk("b_wr_rdata_kept", b_rdata, 0);
    cyc();
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h100;
    cyc();
    b_req = 1'b0;
    chk("b_rd_read_b", read_b, 1);
    chk("b_rd_write", write, 0);
    cyc();
    cyc();
    chk("b_rd_done", b_done, 1);
    chk("b_rd_rdata", b_rdata, 32'h0022_0044);
    cyc();

    // Misaligned port B read
    nb_strb = 0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h102;
    cyc();
    b_req = 1'b0;
    chk("mis_err", b_err, 1);
    chk("mis_not_ready", b_ready, 0);
    cyc();
    chk("mis_err_once", b_err, 0);
    chk("mis_ready_again", b_ready, 1);
    chk("mis_no_strobe", nb_strb, 0);

    // Timeout with no response on port A
    en_a = 1'b0;
    na_strb = 0;
    a_req = 1'b1; a_addr = 32'h0;
    cyc();
    a_req = 1'b0;
    n = 0;
    while (n < 12 && !a_err) begin
      cyc();
      n++;
    end
    chk("to_err", a_err, 1);
    chk("to_strobe_cycles", na_strb, 4);
    chk("to_strobe_low", read_a, 0);
    cyc();
    chk("to_err_once", a_err, 0);
    chk("to_ready", a_ready, 1);
    en_a = 1'b1;

    // Concurrent A read and B write
    rb_seen = 1'b0;
    dca = -1;
    dcb = -1;
    a_req = 1'b1; a_addr = 32'h0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'hCAFE_F00D; b_wmask = 4'hF;
    cyc();
    a_req = 1'b0;
    b_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (a_done && dca < 0) dca = k;
      if (b_done && dcb < 0) dcb = k;
    end
    chk("dp_a_done_seen", 32'(dca >= 0), 1);
    chk("dp_same_cycle", dca, dcb);
    chk("dp_no_read_b", rb_seen, 0);
    chk("dp_a_rdata", a_rdata, 32'h0BAD_F00D);

    // Reset while issuing
    a_req = 1'b1; a_addr = 32'h60;
    cyc();
    a_req = 1'b0;
    chk("mid_strobe", read_a, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_strobe_low", read_a, 0);
    chk("mid_pulses", {a_done, a_err}, 0);
    chk("mid_a_rdata", a_rdata, 0);
    chk("mid_address_a", address_a, 0);
    chk("mid_ready", a_ready, 1);
    cyc();
    chk("mid_no_late_pulse", {a_done, a_err, read_a}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_initiator_dp.md
MEM_INITIATOR_DP -- requirements
Module: mem_initiator_dp

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of request-held cycles before the block abandons a transaction (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have core port A ports: a_req in 1 (fetch request valid); a_addr in 32 (byte address); a_ready out 1 (request accepted this cycle); a_rdata out 32 (fetched word); a_done out 1 (one-cycle completion pulse); a_err out 1 (one-cycle error pulse).
REQ-005 SHALL have core port B ports: b_req in 1; b_we in 1 (1 = write, 0 = read); b_addr in 32; b_wdata in 32; b_wmask in 4; b_ready out 1; b_rdata out 32; b_done out 1; b_err out 1.
REQ-006 SHALL have memory-side ports: read_a out 1, address_a out 32, rdata_a in 32, resp_a in 1; read_b out 1, write out 1, address_b out 32, wdata out 32, wmask out 4, rdata_b in 32, resp_b in 1.

Function
REQ-007 Each port SHALL run an independent FSM with states IDLE, ISSUE, DONE, ERR.
REQ-008 x_ready SHALL be high only in IDLE; a request is accepted when x_req and x_ready are both high at a rising edge, and its address, wdata, wmask and we are registered at that edge.
REQ-009 Acceptance of an aligned request SHALL move IDLE->ISSUE, so the memory strobe is visible the cycle after acceptance.
REQ-010 Acceptance with addr[1:0] != 0 SHALL move IDLE->ERR, no memory strobe is driven, and x_err pulses in the following cycle.
REQ-011 In ISSUE the memory-side strobe (read_a; read_b or write per we), address, wdata and wmask SHALL be held stable every cycle until the strobe is deasserted.
REQ-012 read_b and write SHALL never be high in the same cycle.
REQ-013 In ISSUE, sampling resp high at an edge SHALL capture rdata into x_rdata (reads only) and move to DONE; the strobe is low in DONE.
REQ-014 In DONE, x_done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 x_rdata SHALL hold its last captured value until the next successful read completes; writes leave b_rdata unchanged.
REQ-016 resp SHALL be ignored in IDLE, DONE and ERR, so a resp that remains high for one cycle after the strobe drops is not counted.
REQ-017 A per-port timeout counter SHALL clear on entering ISSUE and increment each ISSUE cycle; if it reaches TIMEOUT without resp, the strobe drops, the FSM moves to ERR, and x_err pulses for one cycle.
REQ-018 ERR SHALL last one cycle and then move to IDLE.
REQ-019 Ports A and B SHALL operate concurrently with no ordering between them, including same-address traffic.
REQ-020 Latency for a read: accept at edge 0, strobe in cycle 1, resp sampled at edge 2, done in cycle 2-3, next accept possible at edge 3.

Reset
REQ-021 When rst is sampled high: both FSMs go to IDLE, timeout counters clear, and outputs are as follows:
- all strobes low;
- done and err low;
- ready high in the following cycle;
- rdata, address, wdata and wmask registers all-zero.
REQ-022 Reset asserted mid-transaction SHALL drop the strobe in the next cycle and discard the transaction with no done or err pulse.

Structure
REQ-023 Package mem_init_pkg SHALL hold the state enum, WORD_W=32, MASK_W=4 and the default TIMEOUT.
REQ-024 A sub-module mem_port_fsm SHALL be parameterized by WRITE_EN and TIMEOUT: instance A has WRITE_EN=0, instance B has WRITE_EN=1.

Verification
REQ-025 Port A read, addr 0x60, memory word 0xDEADBEEF -> read_a high for 2 cycles, a_rdata 0xDEADBEEF, one a_done pulse.
REQ-026 Port B write, addr 0x100, wdata 0x11223344, wmask 4'b0101, then a read of 0x100 with prior contents 0 -> b_rdata 0x00220044.
REQ-027 Port B read with a_addr or b_addr 0x102 -> no strobe at any point, one err pulse, ready high again 2 cycles after acceptance.
REQ-028 resp tied low with TIMEOUT=4 -> strobe high for exactly 4 cycles, then one err pulse, then return to IDLE.
REQ-029 Simultaneous A read at 0x0 and B write at 0x40 -> both done pulses in the same cycle, and read_b never high.
REQ-030 rst asserted in the ISSUE cycle -> strobe low the next cycle, no done or err pulse, all outputs at reset values.
